// File: rtl/aftab_daru_assembler.sv
// Load-side byte assembler: reads 1/2/4 bytes over a byte-wide port, packs them
// little-endian and sign/zero-extends the result for the register file.
module aftab_daru_assembler #(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startDARU,
  input  logic [size-1:0]   addrIn,
  input  logic [1:0]        nBytes,
  input  logic              signExt,
  input  logic [size/4-1:0] dataIn,
  input  logic              memReady,
  output logic [size-1:0]   addrOut,
  output logic              readMem,
  output logic [size-1:0]   dataOut,
  output logic              completeDARU,
  output logic              loadMisalignedFlag,
  output logic              busy
);

  localparam int BW = size / 4;

  typedef enum logic [1:0] {IDLE, READ, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [size-1:0]   addr_q, addr_d;
  logic [1:0]        nbytes_q, nbytes_d;
  logic              sext_q, sext_d;
  logic [BW-1:0]     byte_q [4];
  logic [BW-1:0]     byte_d [4];
  logic              misaligned;
  logic [1:0]        addr_lo;

  assign misaligned = (nBytes == 2'd2) ||
                      (nBytes == 2'd1 && addrIn[0]) ||
                      (nBytes == 2'd3 && addrIn[1:0] != 2'b00);

  // Lane offset wraps in two bits; legal requests never reach the wrap.
  assign addr_lo = addr_q[1:0] + cnt_q;
  assign addrOut = readMem ? {addr_q[size-1:2], addr_lo} : '0;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    addr_d             = addr_q;
    nbytes_d           = nbytes_q;
    sext_d             = sext_q;
    byte_d             = byte_q;
    readMem            = 1'b0;
    completeDARU       = 1'b0;
    loadMisalignedFlag = 1'b0;
    busy               = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (startDARU) begin
          if (misaligned) begin
            state_d = ERR;
          end else begin
            state_d  = READ;
            addr_d   = addrIn;
            nbytes_d = nBytes;
            sext_d   = signExt;
            cnt_d    = 2'd0;
            for (int i = 0; i < 4; i++) byte_d[i] = '0;
          end
        end
      end
      READ: begin
        readMem = 1'b1;
        if (memReady) begin
          byte_d[cnt_q] = dataIn;
          if (cnt_q == nbytes_q) state_d = DONE;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end
      DONE: begin
        completeDARU = 1'b1;
        state_d      = IDLE;
      end
      ERR: begin
        loadMisalignedFlag = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dataOut = '0;
    case (nbytes_q)
      2'd0:    dataOut = {{(size-BW){sext_q & byte_q[0][BW-1]}}, byte_q[0]};
      2'd1:    dataOut = {{(size-2*BW){sext_q & byte_q[1][BW-1]}}, byte_q[1], byte_q[0]};
      default: dataOut = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      nbytes_q <= 2'd0;
      sext_q   <= 1'b0;
      for (int i = 0; i < 4; i++) byte_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nbytes_q <= nbytes_d;
      sext_q   <= sext_d;
      for (int i = 0; i < 4; i++) byte_q[i] <= byte_d[i];
    end
  end

endmodule

// File: doc/aftab_daru_assembler.md
# aftab_daru_assembler

Load-side data adjustment unit of the AFTAB core, the read counterpart of the byte-serial store path. On a load request it checks alignment, reads 1, 2 or 4 bytes sequentially over the byte-wide memory port, assembles them little-endian into a word, sign- or zero-extends it, and returns it to the core with a one-cycle completion pulse. It sits between the core datapath (load result to register file) and the byte-wide data memory interface.

## Interface
- size, 32, core data/address width; byte lanes are size/4 bits wide.

- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- startDARU  in  1  load request; sampled only in IDLE.
- addrIn  in  size  byte address of the load; captured on an accepted start.
- nBytes  in  2  bytes minus one: 0 = byte, 1 = halfword, 3 = word, 2 = illegal.
- signExt  in  1  1 = sign-extend byte/halfword results, 0 = zero-extend.
- dataIn  in  size/4  byte returned by memory.
- memReady  in  1  memory has valid dataIn for the current addrOut.
- addrOut  out  size  byte address to memory; valid while readMem = 1.
- readMem  out  1  memory read strobe.
- dataOut  out  size  assembled, extended load result.
- completeDARU  out  1  one-cycle pulse: dataOut is valid.
- loadMisalignedFlag  out  1  one-cycle pulse: request rejected as misaligned or illegal.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, DONE, ERR.
- IDLE with startDARU = 1:
  - Misaligned or illegal request goes to ERR with no memory access. Misaligned means: nBytes = 2; nBytes = 1 with addrIn[0] = 1; nBytes = 3 with addrIn[1:0] != 0.
  - Otherwise goes to READ. The start cycle captures addrIn, nBytes and signExt, clears the 2-bit byte counter, and clears all four byte registers.
- READ:
  - readMem = 1.
  - addrOut = {addrReg[size-1:2], addrReg[1:0] + cnt}, a 2-bit add with carry discarded. For legal requests the add never wraps.
  - When memReady = 1: byte register[cnt] <= dataIn. If cnt == nBytesReg, go to DONE; otherwise cnt <= cnt + 1.
  - When memReady = 0: hold state, cnt and addrOut.
- DONE: completeDARU = 1, then return to IDLE.
- ERR: loadMisalignedFlag = 1, then return to IDLE. Captured registers are unchanged.
- dataOut is combinational from the byte registers and the captured nBytes/signExt:
  - byte: {{24{signExt & b0[7]}}, b0}
  - halfword: {{16{signExt & b1[7]}}, b1, b0}
  - word: {b3, b2, b1, b0}
- dataOut holds its value from DONE until the next accepted start clears the byte registers.
- startDARU outside IDLE is ignored; no queuing.
- A start in the DONE or ERR cycle is ignored. The earliest back-to-back start is the following IDLE cycle.

## Timing
- Reset values (asynchronous): state IDLE; cnt, all byte registers, addrReg, nBytesReg and signExt register = 0. Outputs: readMem = 0, completeDARU = 0, loadMisalignedFlag = 0, busy = 0, dataOut = 0, addrOut = 0.
- addrOut = 0 whenever readMem = 0.
- Latency with memReady tied high, start accepted at edge 0:
  - readMem high for N cycles, where N = nBytes + 1.
  - completeDARU high in cycle N + 1: byte 2, halfword 3, word 5.
  - Each memReady = 0 cycle in READ adds one cycle.
- Misaligned request: loadMisalignedFlag high in cycle 1, back to IDLE in cycle 2. readMem is never asserted.
- Reset asserted mid-READ: immediate return to IDLE with all outputs 0. No completeDARU or loadMisalignedFlag pulse follows.
- completeDARU and loadMisalignedFlag are never high in the same cycle.

## Test plan
- Word load, addrIn = 0x100, memReady = 1, bytes 0x11,0x22,0x33,0x44 -> addrOut 0x100..0x103 on 4 consecutive readMem cycles; completeDARU in cycle 5; dataOut = 0x44332211.
- Byte load, addrIn = 0x203, signExt = 1, dataIn = 0x80 -> addrOut = 0x203; dataOut = 0xFFFFFF80. Repeat with signExt = 0 -> dataOut = 0x00000080.
- Halfword load, addrIn = 0x0E, signExt = 1, bytes 0x34,0x92 -> dataOut = 0xFFFF9234, completeDARU in cycle 3.
- Misaligned cases: half at 0x101, word at 0x102, nBytes = 2 at 0x100 -> each gives loadMisalignedFlag one cycle, readMem never high, completeDARU never high.
- Word load with memReady low for 2 cycles on byte 1 -> addrOut holds 0x..1 across the stall; completeDARU in cycle 7; dataOut correct. A startDARU pulse during READ is ignored.
- rst pulsed during byte 2 of a word load -> all outputs 0 immediately. A new byte load issued after reset completes normally.
